// File: rtl/clkdiv_multi_if.sv
// Control/status bundle for clkdiv_multi: per-channel enables, ratio writes,
// and the divided-clock, tick and busy outputs.
interface clkdiv_multi_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = 8
) ();
  logic [NUM_CH-1:0]       en_i;
  logic [NUM_CH-1:0]       div_we_i;
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic [NUM_CH-1:0]       busy_o;
  logic [NUM_CH-1:0]       clk_div_o;
  logic [NUM_CH-1:0]       tick_o;

  modport master (
    output en_i, div_we_i, div_i,
    input  busy_o, clk_div_o, tick_o
  );

  modport slave (
    input  en_i, div_we_i, div_i,
    output busy_o, clk_div_o, tick_o
  );
endinterface

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with per-channel tick and a
// boundary-applied ratio update. Optional CLKDIV_SYNC_EN adds sync_i phase reset.
module clkdiv_multi #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef CLKDIV_SYNC_EN
  input  logic sync_i,
`endif
  clkdiv_multi_if.slave ctl
);

  localparam logic [DIV_W-1:0] L_DEF = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] L_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] L_ONE = DIV_W'(1);

  logic [NUM_CH-1:0][DIV_W-1:0] r_cnt;
  logic [NUM_CH-1:0][DIV_W-1:0] r_div;
  logic [NUM_CH-1:0][DIV_W-1:0] r_pend;
  logic [NUM_CH-1:0]            r_busy;
  logic [NUM_CH-1:0]            r_clk;
  logic [NUM_CH-1:0]            r_tick;

  logic [NUM_CH-1:0][DIV_W-1:0] w_clamp;
  logic [NUM_CH-1:0][DIV_W:0]   w_half;
  logic [NUM_CH-1:0]            w_last;
  logic                         w_sync;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync_i;
`else
  assign w_sync = 1'b0;
`endif

  always_comb begin
    w_clamp = '0;
    w_half  = '0;
    w_last  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_clamp[c] = (ctl.div_i[c*DIV_W +: DIV_W] < L_MIN) ? L_MIN
                                                           : ctl.div_i[c*DIV_W +: DIV_W];
      // High phase length ceil(D/2), kept one bit wider so D = 2**DIV_W-1 cannot wrap
      w_half[c]  = ({1'b0, r_div[c]} + (DIV_W+1)'(1)) >> 1;
      w_last[c]  = (r_cnt[c] == (r_div[c] - L_ONE));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_div  <= {NUM_CH{L_DEF}};
      r_pend <= {NUM_CH{L_DEF}};
      r_busy <= '0;
      r_clk  <= '0;
      r_tick <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ctl.div_we_i[c]) begin
          r_pend[c] <= w_clamp[c];
          r_busy[c] <= 1'b1;
        end

        if (w_sync || !ctl.en_i[c]) begin
          r_cnt[c]  <= '0;
          r_clk[c]  <= 1'b0;
          r_tick[c] <= 1'b0;
        end else if (r_cnt[c] == '0) begin
          // Period start: the pending value from before this edge takes effect;
          // a write landing on this same edge stays pending for the next start.
          r_cnt[c]  <= L_ONE;
          r_clk[c]  <= 1'b1;
          r_tick[c] <= 1'b1;
          if (r_busy[c])
            r_div[c] <= r_pend[c];
          if (!ctl.div_we_i[c])
            r_busy[c] <= 1'b0;
        end else begin
          r_tick[c] <= 1'b0;
          r_clk[c]  <= ({1'b0, r_cnt[c]} < w_half[c]);
          r_cnt[c]  <= w_last[c] ? '0 : (r_cnt[c] + L_ONE);
        end
      end
    end
  end

  assign ctl.busy_o    = r_busy;
  assign ctl.clk_div_o = r_clk;
  assign ctl.tick_o    = r_tick;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed self-checking bench for clkdiv_multi (2 channels, DIV_W=8, default ratio 4).
module tb_clkdiv_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef CLKDIV_SYNC_EN
  logic sync = 1'b0;
`endif
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  clkdiv_multi_if #(.NUM_CH(2), .DIV_W(8)) bus ();

  clkdiv_multi #(.NUM_CH(2), .DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
`ifdef CLKDIV_SYNC_EN
    .sync_i(sync),
`endif
    .ctl   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en_i = 2'b00; bus.div_we_i = 2'b00; bus.div_i = '0;
    step(); step();
    n_total++;
    if ({bus.clk_div_o, bus.tick_o, bus.busy_o} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000", {bus.clk_div_o, bus.tick_o, bus.busy_o});
    else n_pass++;
  endtask

  task automatic test_default();
    bit [0:7] ec = 8'b11001100;
    bit [0:7] et = 8'b10001000;
    rst = 1'b0; bus.en_i = 2'b01;
    for (int i = 0; i < 8; i++) begin
      step();
      n_total++;
      if (bus.clk_div_o !== {1'b0, ec[i]} || bus.tick_o !== {1'b0, et[i]})
        $display("FAIL default_div4 cyc%0d: got clk=%b tick=%b expected clk=%b tick=%b",
                 i, bus.clk_div_o, bus.tick_o, {1'b0, ec[i]}, {1'b0, et[i]});
      else n_pass++;
    end
  endtask

  task automatic test_write_mid_period();
    bit [0:8] ec = 9'b100111001;
    bit [0:8] et = 9'b000100001;
    bit [0:8] eb = 9'b111000000;
    step();  // period start, ch0 now mid-period
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin bus.div_we_i = 2'b01; bus.div_i = {8'd0, 8'd5}; end
      step();
      bus.div_we_i = 2'b00;
      n_total++;
      if (bus.clk_div_o[0] !== ec[i] || bus.tick_o[0] !== et[i] || bus.busy_o[0] !== eb[i])
        $display("FAIL write_mid_period cyc%0d: got clk/tick/busy=%b%b%b expected %b%b%b",
                 i, bus.clk_div_o[0], bus.tick_o[0], bus.busy_o[0], ec[i], et[i], eb[i]);
      else n_pass++;
    end
  endtask

  task automatic test_last_write_wins();
    bit [0:7] ec = 8'b11001101;
    bit [0:7] et = 8'b10001001;
    bit [0:7] eb = 8'b11110000;
    bit [7:0] vals [3] = '{8'd0, 8'd1, 8'd3};
    bus.en_i = 2'b01; step();  // ch1 idle with cnt=0
    bus.en_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin bus.div_we_i = 2'b10; bus.div_i = {vals[i], 8'd0}; end
      else bus.div_we_i = 2'b00;
      step();
      n_total++;
      if (bus.clk_div_o[1] !== ec[i] || bus.tick_o[1] !== et[i] || bus.busy_o[1] !== eb[i])
        $display("FAIL last_write_wins cyc%0d: got clk/tick/busy=%b%b%b expected %b%b%b",
                 i, bus.clk_div_o[1], bus.tick_o[1], bus.busy_o[1], ec[i], et[i], eb[i]);
      else n_pass++;
    end
    bus.div_we_i = 2'b00;
  endtask

  task automatic test_clamp_disabled_hold();
    bit [0:3] ec = 4'b1010;
    bus.en_i = 2'b01; step();
    bus.div_we_i = 2'b10; bus.div_i = {8'd1, 8'd0}; step();
    bus.div_we_i = 2'b00; step();
    n_total++;
    if (bus.busy_o[1] !== 1'b1 || bus.clk_div_o[1] !== 1'b0)
      $display("FAIL clamp_held_pending: got busy=%b clk=%b expected busy=1 clk=0",
               bus.busy_o[1], bus.clk_div_o[1]);
    else n_pass++;
    bus.en_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if (bus.clk_div_o[1] !== ec[i] || bus.tick_o[1] !== ec[i] || bus.busy_o[1] !== 1'b0)
        $display("FAIL clamp_div2 cyc%0d: got clk/tick/busy=%b%b%b expected %b%b0",
                 i, bus.clk_div_o[1], bus.tick_o[1], bus.busy_o[1], ec[i], ec[i]);
      else n_pass++;
    end
  endtask

  task automatic test_disable_truncate();
    bit [0:6] ec = 7'b1110001;
    bit [0:6] et = 7'b1000001;
    bus.en_i = 2'b00;
    bus.div_we_i = 2'b01; bus.div_i = {8'd0, 8'd6}; step();
    bus.div_we_i = 2'b00;
    bus.en_i = 2'b01; step(); step();  // start + cycle 2 of D=6
    n_total++;
    if (bus.clk_div_o[0] !== 1'b1 || bus.busy_o[0] !== 1'b0)
      $display("FAIL disable_precheck: got clk=%b busy=%b expected clk=1 busy=0",
               bus.clk_div_o[0], bus.busy_o[0]);
    else n_pass++;
    bus.en_i = 2'b00; step();
    n_total++;
    if (bus.clk_div_o[0] !== 1'b0 || bus.tick_o[0] !== 1'b0)
      $display("FAIL disable_truncate: got clk=%b tick=%b expected 0 0",
               bus.clk_div_o[0], bus.tick_o[0]);
    else n_pass++;
    bus.en_i = 2'b01;
    for (int i = 0; i < 7; i++) begin
      step();
      n_total++;
      if (bus.clk_div_o[0] !== ec[i] || bus.tick_o[0] !== et[i])
        $display("FAIL reenable_div6 cyc%0d: got clk=%b tick=%b expected clk=%b tick=%b",
                 i, bus.clk_div_o[0], bus.tick_o[0], ec[i], et[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_while_busy();
    bit [0:7] ec = 8'b11001100;
    bus.div_we_i = 2'b01; bus.div_i = {8'd0, 8'd9}; step();
    bus.div_we_i = 2'b00;
    n_total++;
    if (bus.busy_o[0] !== 1'b1)
      $display("FAIL busy_before_reset: got %b expected 1", bus.busy_o[0]);
    else n_pass++;
    rst = 1'b1; step();
    n_total++;
    if ({bus.clk_div_o, bus.tick_o, bus.busy_o} !== 6'b0)
      $display("FAIL reset_while_busy: got %b expected 000000", {bus.clk_div_o, bus.tick_o, bus.busy_o});
    else n_pass++;
    rst = 1'b0; bus.en_i = 2'b01;
    for (int i = 0; i < 8; i++) begin
      step();
      n_total++;
      if (bus.clk_div_o[0] !== ec[i] || bus.busy_o[0] !== 1'b0)
        $display("FAIL post_reset_div4 cyc%0d: got clk=%b busy=%b expected clk=%b busy=0",
                 i, bus.clk_div_o[0], bus.busy_o[0], ec[i]);
      else n_pass++;
    end
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    bit [1:0] et [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11};
    bus.en_i = 2'b00;
    bus.div_we_i = 2'b11; bus.div_i = {8'd6, 8'd3}; step();
    bus.div_we_i = 2'b00; bus.en_i = 2'b11;
    for (int i = 0; i < 5; i++) step();
    sync = 1'b1; step(); sync = 1'b0;
    n_total++;
    if (bus.clk_div_o !== 2'b00 || bus.tick_o !== 2'b00)
      $display("FAIL sync_force: got clk=%b tick=%b expected 00 00", bus.clk_div_o, bus.tick_o);
    else n_pass++;
    step();
    n_total++;
    if (bus.tick_o !== 2'b11 || bus.clk_div_o !== 2'b11)
      $display("FAIL sync_in_phase: got clk=%b tick=%b expected 11 11", bus.clk_div_o, bus.tick_o);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      step();
      n_total++;
      if (bus.tick_o !== et[i])
        $display("FAIL sync_ticks cyc%0d: got %b expected %b", i, bus.tick_o, et[i]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_write_mid_period();
    test_last_write_wins();
    test_clamp_disabled_hold();
    test_disable_truncate();
    test_reset_while_busy();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
